// File: rtl/sm83_bus_pkg.sv
// Shared types and constants for the SM83 memory bus controller.
// The state enum covers one M-cycle, and the helpers decode bus phases from the state.
package sm83_bus_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_WAIT,
    ST_T3,
    ST_T4
  } bus_state_t;

  // True from T1 to T3, which is the span where chip-select and write data are driven.
  function automatic logic inAccess(input bus_state_t s);
    return (s == ST_T1) || (s == ST_T2) || (s == ST_WAIT) || (s == ST_T3);
  endfunction

  function automatic logic inStrobe(input bus_state_t s);
    return (s == ST_T2) || (s == ST_WAIT) || (s == ST_T3);
  endfunction

endpackage

// File: rtl/sm83_bus_ctrl_if.sv
// Core-request and memory-bus signal bundle for sm83_bus_ctrl.
// The slave modport is the controller's view. The master modport is the core and memory side.
interface sm83_bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] addr;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, addr, mem_cs, mem_oe, mem_we, mem_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, addr, mem_cs, mem_oe, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/sm83_bus_ctrl.sv
// SM83 M-cycle bus controller: IDLE/T1/T2/WAIT/T3/T4 sequencing with optional wait states.
// The strobes are decoded from the registered state only. The address and read data are held in registers.
module sm83_bus_ctrl
  import sm83_bus_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  sm83_bus_ctrl_if.slave    bus
);

  bus_state_t            r_state;
  logic [WAIT_CNT_W-1:0] r_waitCnt;
  logic [15:0]           r_addr;
  logic                  r_we;
  logic [7:0]            r_wdata;
  logic [7:0]            r_rdata;

  logic w_ready;
  logic w_accept;

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_T4);
  assign w_accept = bus.req_valid & w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_waitCnt <= '0;
      r_addr    <= '0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_T4: begin
          // T4 doubles as an accept slot, so back-to-back accesses leave no idle gap.
          if (w_accept) begin
            r_addr  <= bus.req_addr;
            r_we    <= bus.req_we;
            r_wdata <= bus.req_wdata;
            r_state <= ST_T1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_T1: r_state <= ST_T2;
        ST_T2: begin
          if (WAIT_STATES > 0) begin
            r_waitCnt <= WAIT_CNT_W'(WAIT_STATES);
            r_state   <= ST_WAIT;
          end else begin
            r_state <= ST_T3;
          end
        end
        ST_WAIT: begin
          if (r_waitCnt <= WAIT_CNT_W'(1)) begin
            r_waitCnt <= '0;
            r_state   <= ST_T3;
          end else begin
            r_waitCnt <= r_waitCnt - WAIT_CNT_W'(1);
          end
        end
        ST_T3: begin
          if (!r_we) r_rdata <= bus.mem_rdata;
          r_state <= ST_T4;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_state == ST_T4);
  assign bus.rsp_rdata = r_rdata;
  assign bus.addr      = r_addr;
  assign bus.mem_cs    = inAccess(r_state);
  assign bus.mem_oe    = inStrobe(r_state) & ~r_we;
  assign bus.mem_we    = inStrobe(r_state) & r_we;
  assign bus.mem_wdata = (inAccess(r_state) && r_we) ? r_wdata : 8'h00;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sm83_bus_ctrl.sv
// Directed self-checking bench for sm83_bus_ctrl with zero wait states (busA) and two wait states (busB).
// Cycle n is counted from the cycle in which the request is presented (cycle 0).
module tb_sm83_bus_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sm83_bus_ctrl_if busA ();
  sm83_bus_ctrl_if busB ();

  sm83_bus_ctrl #(.WAIT_STATES(0)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));
  sm83_bus_ctrl #(.WAIT_STATES(2)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit toB, input logic valid, input logic we,
                               input logic [15:0] a, input logic [7:0] wd);
    if (toB) begin
      busB.req_valid = valid; busB.req_we = we; busB.req_addr = a; busB.req_wdata = wd;
    end else begin
      busA.req_valid = valid; busA.req_we = we; busA.req_addr = a; busA.req_wdata = wd;
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    busA.mem_rdata = 8'hA5;
    busB.mem_rdata = 8'h77;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_req_ready", busA.req_ready, 1);
    checkOutput("rst_busy", busA.busy, 0);
    checkOutput("rst_addr", busA.addr, 16'h0000);
    checkOutput("rst_cs_oe_we", {busA.mem_cs, busA.mem_oe, busA.mem_we}, 3'b000);
    checkOutput("rst_rsp_valid", busA.rsp_valid, 0);
    checkOutput("rst_rsp_rdata", busA.rsp_rdata, 8'h00);
    checkOutput("rst_mem_wdata", busA.mem_wdata, 8'h00);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // Read 0x0010 with mem_rdata 0xA5
    $display("[TB] read 0x0010, no wait states");
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      if (c == 1) applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 8'hEE);
      checkOutput($sformatf("rd_cs_c%0d", c), busA.mem_cs, (c <= 3));
      checkOutput($sformatf("rd_oe_c%0d", c), busA.mem_oe, (c == 2 || c == 3));
      checkOutput($sformatf("rd_we_c%0d", c), busA.mem_we, 0);
      checkOutput($sformatf("rd_rsp_valid_c%0d", c), busA.rsp_valid, (c == 4));
      checkOutput($sformatf("rd_addr_c%0d", c), busA.addr, 16'h0010);
      checkOutput($sformatf("rd_busy_c%0d", c), busA.busy, (c <= 4));
      if (c == 4) checkOutput("rd_rsp_rdata", busA.rsp_rdata, 8'hA5);
    end

    // Write 0xC123 data 0x5A; rsp_rdata must keep 0xA5
    $display("[TB] write 0xC123 <= 0x5A");
    busA.mem_rdata = 8'h3C;
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hC123, 8'h5A);
    for (int c = 1; c <= 5; c++) begin
      nextCycle();
      if (c == 1) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      checkOutput($sformatf("wr_cs_c%0d", c), busA.mem_cs, (c <= 3));
      checkOutput($sformatf("wr_we_c%0d", c), busA.mem_we, (c == 2 || c == 3));
      checkOutput($sformatf("wr_oe_c%0d", c), busA.mem_oe, 0);
      checkOutput($sformatf("wr_wdata_c%0d", c), busA.mem_wdata, (c <= 3) ? 8'h5A : 8'h00);
      checkOutput($sformatf("wr_rsp_valid_c%0d", c), busA.rsp_valid, (c == 4));
      checkOutput($sformatf("wr_addr_c%0d", c), busA.addr, 16'hC123);
      checkOutput($sformatf("wr_rsp_rdata_c%0d", c), busA.rsp_rdata, 8'hA5);
    end

    // Back-to-back reads 0x0000 then 0x0001 with req_valid held high
    $display("[TB] back-to-back reads");
    busA.mem_rdata = 8'h11;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
    for (int c = 1; c <= 9; c++) begin
      nextCycle();
      checkOutput($sformatf("b2b_rsp_valid_c%0d", c), busA.rsp_valid, (c == 4 || c == 8));
      checkOutput($sformatf("b2b_ready_c%0d", c), busA.req_ready, (c == 4 || c == 8 || c == 9));
      checkOutput($sformatf("b2b_addr_c%0d", c), busA.addr, (c <= 4) ? 16'h0000 : 16'h0001);
      checkOutput($sformatf("b2b_busy_c%0d", c), busA.busy, (c <= 8));
      if (c == 4) checkOutput("b2b_rdata_first", busA.rsp_rdata, 8'h11);
      if (c == 8) checkOutput("b2b_rdata_second", busA.rsp_rdata, 8'h22);
      if (c == 4) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0001, 8'h00);
      if (c == 5) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        busA.mem_rdata = 8'h22;
      end
    end

    // Two wait states: read 0xD000
    $display("[TB] read 0xD000, two wait states");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hD000, 8'h00);
    for (int c = 1; c <= 7; c++) begin
      nextCycle();
      if (c == 1) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
      checkOutput($sformatf("ws_cs_c%0d", c), busB.mem_cs, (c <= 5));
      checkOutput($sformatf("ws_oe_c%0d", c), busB.mem_oe, (c >= 2 && c <= 5));
      checkOutput($sformatf("ws_rsp_valid_c%0d", c), busB.rsp_valid, (c == 6));
      checkOutput($sformatf("ws_addr_c%0d", c), busB.addr, 16'hD000);
      if (c == 6) checkOutput("ws_rsp_rdata", busB.rsp_rdata, 8'h77);
    end

    // Reset during T2 of a read
    $display("[TB] reset abort in T2");
    busA.mem_rdata = 8'h99;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    nextCycle();
    checkOutput("abort_pre_oe", busA.mem_oe, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_strobes", {busA.mem_cs, busA.mem_oe, busA.mem_we}, 3'b000);
    checkOutput("abort_busy", busA.busy, 0);
    checkOutput("abort_addr", busA.addr, 16'h0000);
    checkOutput("abort_rsp_rdata", busA.rsp_rdata, 8'h00);
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      checkOutput($sformatf("abort_rsp_valid_%0d", c), busA.rsp_valid, 0);
    end
    rst_n = 1'b1;
    checkOutput("abort_ready_release", busA.req_ready, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0042, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      if (c == 1) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      checkOutput($sformatf("post_busy_c%0d", c), busA.busy, 1);
      checkOutput($sformatf("post_addr_c%0d", c), busA.addr, 16'h0042);
      checkOutput($sformatf("post_rsp_valid_c%0d", c), busA.rsp_valid, (c == 4));
      if (c == 4) checkOutput("post_rsp_rdata", busA.rsp_rdata, 8'h99);
    end

    nextCycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm83_bus_ctrl.md
SM83_BUS_CTRL -- requirements
Module: sm83_bus_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, extra T2-hold cycles per access, legal range 0..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  core requests a memory access.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request this cycle.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read; sampled on accept.
REQ-007 SHALL have port req_addr  input  16  access address; sampled on accept.
REQ-008 SHALL have port req_wdata  input  8  write data; sampled on accept.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle pulse marking access completion, for reads and writes.
REQ-010 SHALL have port rsp_rdata  output  8  last completed read data.
REQ-011 SHALL have port addr  output  16  registered bus address to the address decoder.
REQ-012 SHALL have port mem_cs  output  1  bus chip-select to the address decoder.
REQ-013 SHALL have port mem_oe  output  1  bus output-enable to the address decoder.
REQ-014 SHALL have port mem_we  output  1  bus write strobe.
REQ-015 SHALL have port mem_wdata  output  8  write data bus.
REQ-016 SHALL have port mem_rdata  input  8  read data from selected memory.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, T1, T2, WAIT, T3, T4 modelling one SM83 M-cycle.
REQ-019 SHALL assert req_ready only in IDLE and T4; accept = req_valid & req_ready.
REQ-020 SHALL on accept capture req_addr/req_we/req_wdata and go to T1; without accept, IDLE stays and T4 goes to IDLE.
REQ-021 SHALL transition T1->T2; T2->WAIT if WAIT_STATES>0, else T3; WAIT->T3 after exactly WAIT_STATES cycles in WAIT (4-bit down-counter); T3->T4.
REQ-022 SHALL hold addr at the captured value from the cycle after accept until the next accept.
REQ-023 SHALL assert mem_cs in T1, T2, WAIT, T3; deasserted in IDLE and T4.
REQ-024 SHALL assert mem_oe in T2, WAIT, T3 for reads only; mem_we in T2, WAIT, T3 for writes only; never both.
REQ-025 SHALL drive mem_wdata with captured data in T1..T3 of writes, 0x00 otherwise.
REQ-026 SHALL latch mem_rdata into rsp_rdata at the T3->T4 edge for reads; writes leave rsp_rdata unchanged.
REQ-027 SHALL pulse rsp_valid in T4 only; accept-to-rsp_valid latency 4+WAIT_STATES cycles.
REQ-028 SHALL support back-to-back accesses (accept in T4 -> T1), giving one access every 4+WAIT_STATES cycles with no idle gap.
REQ-029 SHALL ignore req_* changes outside accept cycles.

Reset
REQ-030 SHALL on rst_n low immediately force state IDLE, wait counter 0, addr 0x0000, rsp_rdata 0x00, mem_wdata 0x00, mem_cs/mem_oe/mem_we/rsp_valid/busy 0; req_ready 1.
REQ-031 SHALL abort an in-flight access on reset with no rsp_valid for it, and accept a new request on the first edge after rst_n rises.

Structure
REQ-032 SHALL take the state encoding (enum) and wait-counter width constant from shared package sm83_bus_pkg.
REQ-033 SHALL be a single module with no sub-modules; outputs are registered or decoded from the registered state only.

Verification
REQ-034 SHALL cover: WAIT_STATES=0, read 0x0010, mem_rdata=0xA5 -> mem_cs cycles 1-3, mem_oe cycles 2-3, rsp_valid cycle 4, rsp_rdata=0xA5.
REQ-035 SHALL cover: write 0xC123 data 0x5A -> mem_we cycles 2-3, mem_oe never high, mem_wdata=0x5A cycles 1-3, rsp_valid cycle 4, rsp_rdata unchanged.
REQ-036 SHALL cover: req_valid held high for reads 0x0000 then 0x0001 -> second accepted in T4, rsp_valid at cycles 4 and 8, addr switches to 0x0001 at cycle 5.
REQ-037 SHALL cover: WAIT_STATES=2, read 0xD000 -> mem_oe high 4 cycles, rsp_valid at cycle 6.
REQ-038 SHALL cover: rst_n low during T2 of a read -> all strobes 0 immediately, no rsp_valid, req_ready=1 after release.
